dht11_frame_decoder: RTL and testbench

Downstream consumer of the DHT11 sensor interface's 40-bit frame. On a frame-complete pulse it latches the frame and classifies it as OK, sensor error or checksum error. For good frames it converts the humidity and temperature integer bytes to 3-digit BCD with a sequential double-dabble. It then presents the result to the display/UART layer over a valid/ready handshake.

---
 rtl/dht_pkg.sv | 41 ++++
 rtl/dht11_frame_decoder_bin8_to_bcd3.sv | 49 ++++
 rtl/dht11_frame_decoder.sv | 132 +++++++++++++
 tb/tb_dht11_frame_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11 frame decoder: FSM states, status codes,
// frame byte layout and default error constants.
package dht_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_CONV_HUM  = 3'd2,
    S_CONV_TEMP = 3'd3,
    S_PRESENT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_SENSOR_ERR = 2'b01,
    ST_CHK_ERR    = 2'b10
  } status_t;

  // Byte index inside the 40-bit frame (byte 4 is the MSB byte).
  localparam int B_HUM_INT   = 4;
  localparam int B_HUM_FRAC  = 3;
  localparam int B_TEMP_INT  = 2;
  localparam int B_TEMP_FRAC = 1;
  localparam int B_CHKSUM    = 0;

  localparam logic [39:0] SENSOR_ERR_PATTERN_DEF = 40'hFF_FFFF_FFFF;
  localparam logic [11:0] ERR_BCD_DEF            = 12'hEEE;

  function automatic logic [7:0] frame_byte(input logic [39:0] f, input int idx);
    return f[idx*8 +: 8];
  endfunction

  // Checksum is the low 8 bits of the sum of the four data bytes.
  function automatic logic checksum_ok(input logic [39:0] f);
    logic [7:0] sum;
    sum = frame_byte(f, B_HUM_INT) + frame_byte(f, B_HUM_FRAC)
        + frame_byte(f, B_TEMP_INT) + frame_byte(f, B_TEMP_FRAC);
    return sum == frame_byte(f, B_CHKSUM);
  endfunction

endpackage

// File: rtl/dht11_frame_decoder_bin8_to_bcd3.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble), one
// iteration per clock; o_done is high during the 8th iteration with o_bcd valid.
module bin8_to_bcd3 (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_run;

  logic [11:0] w_adj;
  logic [19:0] w_sh;

  for (genvar n = 0; n < 3; n++) begin : g_nib
    assign w_adj[n*4 +: 4] = (r_bcd[n*4 +: 4] >= 4'd5) ? r_bcd[n*4 +: 4] + 4'd3
                                                       : r_bcd[n*4 +: 4];
  end

  // The hundreds digit never exceeds 2, so the bit shifted out of the top is always 0.
  assign w_sh   = {w_adj, r_bin} << 1;
  assign o_bcd  = w_sh[19:8];
  assign o_done = r_run && (r_cnt == 4'd7);

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_bin <= w_sh[7:0];
      r_bcd <= w_sh[19:8];
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd7) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/dht11_frame_decoder.sv
// DHT11 frame decoder: classify a 40-bit frame, convert integer bytes to BCD,
// present over valid/ready. Optional macro DHT_LAST_GOOD_HOLD_EN keeps the last
// good readings on error frames.
module dht11_frame_decoder
  import dht_pkg::*;
#(
  parameter logic [11:0] ERR_BCD            = ERR_BCD_DEF,
  parameter logic [39:0] SENSOR_ERR_PATTERN = SENSOR_ERR_PATTERN_DEF
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic [39:0] frame_in,
  input  logic        frame_done,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  status,
  output logic [11:0] hum_bcd,
  output logic [11:0] temp_bcd,
  output logic [7:0]  hum_frac,
  output logic [7:0]  temp_frac,
  output logic        overrun,
  output logic        busy
);

  state_t      r_state, w_next;
  logic [39:0] r_frame;
  logic [1:0]  r_status;
  logic [11:0] r_hum_bcd, r_temp_bcd;
  logic [7:0]  r_hum_frac, r_temp_frac;
  logic        r_overrun;

  status_t     w_status;
  logic        w_err;
  logic        w_conv_start;
  logic [7:0]  w_conv_bin;
  logic        w_conv_done;
  logic [11:0] w_conv_bcd;

  always_comb begin
    w_status = ST_OK;
    if (r_frame == SENSOR_ERR_PATTERN) w_status = ST_SENSOR_ERR;
    else if (!checksum_ok(r_frame))    w_status = ST_CHK_ERR;
  end
  assign w_err = (w_status != ST_OK);

  bin8_to_bcd3 u_bcd (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .i_start   (w_conv_start),
    .i_bin     (w_conv_bin),
    .o_done    (w_conv_done),
    .o_bcd     (w_conv_bcd)
  );

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (frame_done)  w_next = S_CHECK;
      S_CHECK:     w_next = w_err ? S_PRESENT : S_CONV_HUM;
      S_CONV_HUM:  if (w_conv_done) w_next = S_CONV_TEMP;
      S_CONV_TEMP: if (w_conv_done) w_next = S_PRESENT;
      S_PRESENT:   if (out_ready)   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // The converter is reloaded with temp_int in the same cycle humidity finishes.
  always_comb begin
    out_valid    = 1'b0;
    busy         = (r_state != S_IDLE);
    w_conv_start = 1'b0;
    w_conv_bin   = frame_byte(r_frame, B_HUM_INT);
    case (r_state)
      S_CHECK:    w_conv_start = !w_err;
      S_CONV_HUM: begin
        w_conv_start = w_conv_done;
        w_conv_bin   = frame_byte(r_frame, B_TEMP_INT);
      end
      S_PRESENT:  out_valid = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      r_frame     <= '0;
      r_status    <= ST_OK;
      r_hum_bcd   <= '0;
      r_temp_bcd  <= '0;
      r_hum_frac  <= '0;
      r_temp_frac <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (frame_done && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (frame_done) r_frame <= frame_in;
        S_CHECK: begin
          r_status <= w_status;
`ifdef DHT_LAST_GOOD_HOLD_EN
`else
          if (w_err) begin
            r_hum_bcd   <= ERR_BCD;
            r_temp_bcd  <= ERR_BCD;
            r_hum_frac  <= '0;
            r_temp_frac <= '0;
          end
`endif
        end
        S_CONV_HUM: if (w_conv_done) r_hum_bcd <= w_conv_bcd;
        S_CONV_TEMP: if (w_conv_done) begin
          r_temp_bcd  <= w_conv_bcd;
          r_hum_frac  <= frame_byte(r_frame, B_HUM_FRAC);
          r_temp_frac <= frame_byte(r_frame, B_TEMP_FRAC);
        end
        default: ;
      endcase
    end
  end

  assign status    = r_status;
  assign hum_bcd   = r_hum_bcd;
  assign temp_bcd  = r_temp_bcd;
  assign hum_frac  = r_hum_frac;
  assign temp_frac = r_temp_frac;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_dht11_frame_decoder.sv
// Self-checking bench for dht11_frame_decoder: timeline reference model,
// per-cycle compare, directed literal checks and randomized frames.
module tb_dht11_frame_decoder;

  logic        clk_50MHz = 1'b0;
  logic        rst;
  logic [39:0] frame_in;
  logic        frame_done;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  status;
  logic [11:0] hum_bcd, temp_bcd;
  logic [7:0]  hum_frac, temp_frac;
  logic        overrun, busy;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  dht11_frame_decoder dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .frame_in  (frame_in),
    .frame_done(frame_done),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .status    (status),
    .hum_bcd   (hum_bcd),
    .temp_bcd  (temp_bcd),
    .hum_frac  (hum_frac),
    .temp_frac (temp_frac),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [1:0] classify(input logic [39:0] f);
    int s;
    if (f == 40'hFF_FFFF_FFFF) return 2'b01;
    s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    return (s != int'(f[7:0])) ? 2'b10 : 2'b00;
  endfunction

  logic        m_busy, m_pres, m_ovr;
  int          m_cnt, m_lat;
  logic [1:0]  m_status, p_status;
  logic [11:0] m_hum, m_temp, p_hum, p_temp;
  logic [7:0]  m_hf, m_tf, p_hf, p_tf;

  // Cycle-count view: a frame accepted in cycle 0 is shown from cycle 18 (good) or 2 (error).
  always @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      m_busy <= 0; m_pres <= 0; m_ovr <= 0; m_cnt <= 0; m_lat <= 0;
      m_status <= 0; m_hum <= 0; m_temp <= 0; m_hf <= 0; m_tf <= 0;
      p_status <= 0; p_hum <= 0; p_temp <= 0; p_hf <= 0; p_tf <= 0;
    end else begin
      if (frame_done && m_busy) m_ovr <= 1'b1;
      if (m_pres) begin
        if (out_ready) begin m_pres <= 0; m_busy <= 0; end
      end else if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == m_lat) begin
          m_pres <= 1; m_status <= p_status;
          m_hum <= p_hum; m_temp <= p_temp; m_hf <= p_hf; m_tf <= p_tf;
        end
      end else if (frame_done) begin
        m_busy   <= 1;
        m_cnt    <= 1;
        p_status <= classify(frame_in);
        if (classify(frame_in) == 2'b00) begin
          m_lat  <= 18;
          p_hum  <= to_bcd(int'(frame_in[39:32]));
          p_temp <= to_bcd(int'(frame_in[23:16]));
          p_hf   <= frame_in[31:24];
          p_tf   <= frame_in[15:8];
        end else begin
          m_lat <= 2;
`ifdef DHT_LAST_GOOD_HOLD_EN
          p_hum <= m_hum; p_temp <= m_temp; p_hf <= m_hf; p_tf <= m_tf;
`else
          p_hum <= 12'hEEE; p_temp <= 12'hEEE; p_hf <= 0; p_tf <= 0;
`endif
        end
      end
    end
  end

  // Per-cycle compare; result outputs are meaningful when presenting or idle.
  always @(negedge clk_50MHz) begin
    if (cmp_en) begin
      check("busy", 40'(busy), 40'(m_busy));
      check("out_valid", 40'(out_valid), 40'(m_pres));
      check("overrun", 40'(overrun), 40'(m_ovr));
      if (!m_busy || m_pres) begin
        check("status", 40'(status), 40'(m_status));
        check("hum_bcd", 40'(hum_bcd), 40'(m_hum));
        check("temp_bcd", 40'(temp_bcd), 40'(m_temp));
        check("hum_frac", 40'(hum_frac), 40'(m_hf));
        check("temp_frac", 40'(temp_frac), 40'(m_tf));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [39:0] f);
    @(negedge clk_50MHz);
    frame_in   = f;
    frame_done = 1'b1;
    @(negedge clk_50MHz);
    frame_done = 1'b0;
  endtask

  // Called in cycle 1 after send; returns the cycle index at which out_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk_50MHz);
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int lat_exp, input int lat,
                              input logic [1:0] st, input logic [11:0] h, input logic [11:0] t);
    check({tag, "_latency"}, 40'(lat), 40'(lat_exp));
    check({tag, "_status"}, 40'(status), 40'(st));
    check({tag, "_hum"}, 40'(hum_bcd), 40'(h));
    check({tag, "_temp"}, 40'(temp_bcd), 40'(t));
  endtask

  function automatic logic [39:0] good_frame(input logic [7:0] hi, input logic [7:0] hf,
                                             input logic [7:0] ti, input logic [7:0] tf);
    logic [7:0] c;
    c = hi + hf + ti + tf;
    return {hi, hf, ti, tf, c};
  endfunction

  initial begin
    int lat, k;
    logic [7:0] edge_v [6];
    edge_v = '{8'd0, 8'd9, 8'd99, 8'd100, 8'd199, 8'd255};
    rst = 1'b0; frame_in = '0; frame_done = 1'b0; out_ready = 1'b1;
    #1;
    check("reset_valid", 40'(out_valid), 40'd0);
    check("reset_busy", 40'(busy), 40'd0);
    check("reset_status", 40'(status), 40'd0);
    check("reset_hum", 40'(hum_bcd), 40'd0);
    #44 rst = 1'b1;
    cmp_en = 1'b1;

    send(40'h37_00_1A_00_51);
    wait_valid(lat);
    check_result("ok1", 18, lat, 2'b00, 12'h055, 12'h026);
    check("ok1_fracs", 40'({hum_frac, temp_frac}), 40'd0);

    @(negedge clk_50MHz);
    send(40'h37_00_1A_00_50);
    wait_valid(lat);
`ifdef DHT_LAST_GOOD_HOLD_EN
    check_result("chk", 2, lat, 2'b10, 12'h055, 12'h026);
`else
    check_result("chk", 2, lat, 2'b10, 12'hEEE, 12'hEEE);
`endif

    @(negedge clk_50MHz);
    send(40'hFF_FFFF_FFFF);
    wait_valid(lat);
`ifdef DHT_LAST_GOOD_HOLD_EN
    check_result("sens", 2, lat, 2'b01, 12'h055, 12'h026);
`else
    check_result("sens", 2, lat, 2'b01, 12'hEEE, 12'hEEE);
`endif

    @(negedge clk_50MHz);
    send(40'hFF_00_00_00_FF);
    wait_valid(lat);
    check_result("max", 18, lat, 2'b00, 12'h255, 12'h000);

    // Back-pressure hold with a dropped frame during PRESENT
    @(negedge clk_50MHz);
    out_ready = 1'b0;
    send(good_frame(8'd42, 8'd5, 8'd21, 8'd3));
    wait_valid(lat);
    check_result("hold", 18, lat, 2'b00, 12'h042, 12'h021);
    repeat (20) @(negedge clk_50MHz);
    send(good_frame(8'd11, 8'd0, 8'd12, 8'd0));
    repeat (28) @(negedge clk_50MHz);
    check("hold_overrun", 40'(overrun), 40'd1);
    check("hold_valid", 40'(out_valid), 40'd1);
    check("hold_hum", 40'(hum_bcd), 40'h042);
    check("hold_hfrac", 40'(hum_frac), 40'd5);
    out_ready = 1'b1;
    @(negedge clk_50MHz);
    check("hold_idle", 40'(busy), 40'd0);

    // Reset during humidity conversion
    send(40'h37_00_1A_00_51);
    repeat (7) @(negedge clk_50MHz);
    #3 rst = 1'b0;
    #1;
    check("mrst_busy", 40'(busy), 40'd0);
    check("mrst_overrun", 40'(overrun), 40'd0);
    check("mrst_hum", 40'(hum_bcd), 40'd0);
    check("mrst_status", 40'(status), 40'd0);
    @(negedge clk_50MHz);
    #3 rst = 1'b1;
    send(good_frame(8'd87, 8'd1, 8'd35, 8'd9));
    wait_valid(lat);
    check_result("post_rst", 18, lat, 2'b00, 12'h087, 12'h035);

    // Randomized frames with random back-pressure and stray frame_done pulses
    for (int i = 0; i < 40; i++) begin
      logic [39:0] f;
      case ($urandom_range(0, 3))
        0: f = 40'hFF_FFFF_FFFF;
        1: f = good_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        2: f = {8'($urandom), 32'($urandom)};
        default: f = good_frame(edge_v[$urandom_range(0, 5)], 8'($urandom),
                                edge_v[$urandom_range(0, 5)], 8'($urandom));
      endcase
      @(negedge clk_50MHz);
      send(f);
      k = 0;
      while (busy && k < 300) begin
        out_ready  = ($urandom_range(0, 3) != 0);
        frame_done = ($urandom_range(0, 9) == 0);
        frame_in   = {8'($urandom), 32'($urandom)};
        @(negedge clk_50MHz);
        k++;
      end
      frame_done = 1'b0;
      out_ready  = 1'b1;
      if (k >= 300) check("rand_timeout", 40'd1, 40'd0);
    end

    repeat (3) @(negedge clk_50MHz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
